// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: core-side request/response ports plus shared slave bus for the arbiter
interface bus_arbiter_if;
  logic        imem_valid;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        imem_error;
  logic        dmem_valid;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        dmem_error;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        bram_valid;
  logic        uart_valid;
  logic        clint_valid;
  logic        plic_valid;
  logic        bram_ready;
  logic        uart_ready;
  logic        clint_ready;
  logic        plic_ready;
  logic [31:0] bram_rdata;
  logic [31:0] uart_rdata;
  logic [31:0] clint_rdata;
  logic [31:0] plic_rdata;
  modport master (
    output imem_valid, imem_addr, dmem_valid, dmem_addr, dmem_wdata, dmem_wstrb,
    output bram_ready, uart_ready, clint_ready, plic_ready,
    output bram_rdata, uart_rdata, clint_rdata, plic_rdata,
    input  imem_ready, imem_rdata, imem_error, dmem_ready, dmem_rdata, dmem_error,
    input  mem_instr, mem_addr, mem_wdata, mem_wstrb,
    input  bram_valid, uart_valid, clint_valid, plic_valid
  );
  modport slave (
    input  imem_valid, imem_addr, dmem_valid, dmem_addr, dmem_wdata, dmem_wstrb,
    input  bram_ready, uart_ready, clint_ready, plic_ready,
    input  bram_rdata, uart_rdata, clint_rdata, plic_rdata,
    output imem_ready, imem_rdata, imem_error, dmem_ready, dmem_rdata, dmem_error,
    output mem_instr, mem_addr, mem_wdata, mem_wstrb,
    output bram_valid, uart_valid, clint_valid, plic_valid
  );
endinterface

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin imem/dmem arbiter with address decode, single outstanding access and timeout
module bus_arbiter #(
  parameter int          BRAM_DEPTH = 12,
  parameter logic [31:0] UART_BASE  = 32'h00100000,
  parameter logic [31:0] UART_TOP   = 32'h00100004,
  parameter logic [31:0] CLINT_BASE = 32'h02000000,
  parameter logic [31:0] CLINT_TOP  = 32'h0200C000,
  parameter logic [31:0] PLIC_BASE  = 32'h0C000000,
  parameter logic [31:0] PLIC_TOP   = 32'h10000000,
  parameter int          TIMEOUT    = 256
) (
  input logic         clock,
  input logic         reset,
  bus_arbiter_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT + 2);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state, state_n;
  logic          last_d;
  logic [3:0]    sel_q;
  logic [31:0]   rdata_q;
  logic          err_q;
  logic [CW-1:0] cnt;
  logic          req, pick_d, sel_ready, timed_out;
  logic [31:0]   req_addr, sel_rdata;
  logic [3:0]    req_sel;
  function automatic logic [3:0] decode(input logic [31:0] a);
    decode = {a >= PLIC_BASE && a < PLIC_TOP,
              a >= CLINT_BASE && a < CLINT_TOP,
              a >= UART_BASE && a < UART_TOP,
              {1'b0, a} < (33'd1 << (BRAM_DEPTH + 2))};
  endfunction
  // Grant choice, decode of the winning address, and next-state selection
  always_comb begin
    state_n   = state;
    req       = bus.imem_valid | bus.dmem_valid;
    pick_d    = bus.dmem_valid & (~bus.imem_valid | ~last_d);
    req_addr  = pick_d ? bus.dmem_addr : bus.imem_addr;
    req_sel   = decode(req_addr);
    sel_ready = |(sel_q & {bus.plic_ready, bus.clint_ready, bus.uart_ready, bus.bram_ready});
    sel_rdata = ({32{sel_q[0]}} & bus.bram_rdata) | ({32{sel_q[1]}} & bus.uart_rdata) |
                ({32{sel_q[2]}} & bus.clint_rdata) | ({32{sel_q[3]}} & bus.plic_rdata);
    timed_out = TIMEOUT != 0 && cnt == CW'(TIMEOUT - 1);
    if (state == IDLE && req) state_n = |req_sel ? ACCESS : RESP;
    else if (state == ACCESS && (sel_ready || timed_out)) state_n = RESP;
    else if (state == RESP) state_n = IDLE;
  end
  // State register
  always_ff @(posedge clock) state <= !reset ? IDLE : state_n;
  // Latch the granted request on entry, count access cycles, capture the response
  always_ff @(posedge clock) begin
    if (!reset) begin
      last_d        <= 1'b0;
      sel_q         <= '0;
      rdata_q       <= '0;
      err_q         <= 1'b0;
      cnt           <= '0;
      bus.mem_instr <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_wstrb <= '0;
    end else if (state == IDLE && req) begin
      last_d        <= pick_d;
      sel_q         <= req_sel;
      rdata_q       <= '0;
      err_q         <= ~|req_sel;
      cnt           <= '0;
      bus.mem_instr <= ~pick_d;
      bus.mem_addr  <= req_addr;
      bus.mem_wdata <= pick_d ? bus.dmem_wdata : '0;
      bus.mem_wstrb <= pick_d ? bus.dmem_wstrb : '0;
    end else if (state == ACCESS) begin
      cnt     <= cnt + 1'b1;
      rdata_q <= sel_ready ? sel_rdata : '0;
      err_q   <= ~sel_ready & timed_out;
    end
  end
  assign bus.bram_valid  = state == ACCESS && sel_q[0];
  assign bus.uart_valid  = state == ACCESS && sel_q[1];
  assign bus.clint_valid = state == ACCESS && sel_q[2];
  assign bus.plic_valid  = state == ACCESS && sel_q[3];
  assign bus.imem_ready  = state == RESP && !last_d;
  assign bus.dmem_ready  = state == RESP && last_d;
  assign bus.imem_rdata  = bus.imem_ready ? rdata_q : '0;
  assign bus.dmem_rdata  = bus.dmem_ready ? rdata_q : '0;
  assign bus.imem_error  = bus.imem_ready & err_q;
  assign bus.dmem_error  = bus.dmem_ready & err_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: transaction-level model plus directed scenarios for bus_arbiter
module tb_bus_arbiter;
  localparam int TO = 8;
  logic clock = 1'b0;
  logic reset = 1'b0;
  bus_arbiter_if bus();
  bus_arbiter #(.TIMEOUT(TO)) dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;

  int checks = 0;
  int passed = 0;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", n, act, exp);
  endtask

  // slave responders: ready once valid has been high lat[s] cycles (0 = never), noise forces ready
  int          lat[4] = '{1, 3, 1, 0};
  logic [3:0]  noise = 4'b0;
  logic [31:0] srd[4] = '{32'hDEADBEEF, 32'h00000055, 32'h12345678, 32'hCAFEF00D};
  int          k[4] = '{0, 0, 0, 0};
  logic [3:0]  rdy = 4'b0;
  logic [3:0]  sv;
  assign sv = {bus.plic_valid, bus.clint_valid, bus.uart_valid, bus.bram_valid};
  assign bus.bram_ready  = rdy[0];
  assign bus.uart_ready  = rdy[1];
  assign bus.clint_ready = rdy[2];
  assign bus.plic_ready  = rdy[3];
  assign bus.bram_rdata  = srd[0];
  assign bus.uart_rdata  = srd[1];
  assign bus.clint_rdata = srd[2];
  assign bus.plic_rdata  = srd[3];
  initial forever begin
    @(posedge clock);
    #1;
    for (int s = 0; s < 4; s++) begin
      k[s] = sv[s] ? k[s] + 1 : 0;
      rdy[s] = noise[s] | (lat[s] != 0 && k[s] >= lat[s]);
    end
  end

  function automatic int region(input logic [31:0] a);
    if (a < 32'h00004000) return 0;
    if (a >= 32'h00100000 && a < 32'h00100004) return 1;
    if (a >= 32'h02000000 && a < 32'h0200C000) return 2;
    if (a >= 32'h0C000000 && a < 32'h10000000) return 3;
    return -1;
  endfunction

  // model: one transaction at a time described by its grant cycle, target and response cycle
  int          cyc = 0;
  bit          act = 0, lastd = 0, twho = 0, prst = 1, pd;
  int          ts = -1, st = 0, rc = -1;
  logic [31:0] ta = '0, twd = '0, rd = '0;
  logic [3:0]  tws = '0, esv;
  bit          re = 0;
  int          nvalid[4], nir, ndr, ir_cyc, dr_cyc, last_sv[4];
  logic [31:0] ird, drd;
  bit          ierr, derr;
  bit          order[$];

  always @(negedge clock) begin
    cyc++;
    esv = (act && ts >= 0 && cyc > st && (rc < 0 || cyc < rc)) ? 4'(1 << ts) : 4'b0;
    chk("slave_valid", 32'(sv), 32'(esv));
    chk("imem_ready", 32'(bus.imem_ready), 32'(act && cyc == rc && !twho));
    chk("dmem_ready", 32'(bus.dmem_ready), 32'(act && cyc == rc && twho));
    if (act && cyc == rc) begin
      chk("resp_rdata", twho ? bus.dmem_rdata : bus.imem_rdata, rd);
      chk("resp_error", 32'(twho ? bus.dmem_error : bus.imem_error), 32'(re));
    end
    if (esv != 0) begin
      chk("mem_addr", bus.mem_addr, ta);
      chk("mem_instr", 32'(bus.mem_instr), 32'(!twho));
      chk("mem_wstrb", 32'(bus.mem_wstrb), 32'(tws));
      if (twho) chk("mem_wdata", bus.mem_wdata, twd);
    end
    if (prst) begin
      chk("rst_mem_addr", bus.mem_addr, 32'h0);
      chk("rst_mem_ctl", {bus.mem_instr, bus.mem_wstrb, bus.imem_ready, bus.dmem_ready}, 32'h0);
    end
    for (int s = 0; s < 4; s++) if (sv[s]) begin nvalid[s]++; last_sv[s] = cyc; end
    if (bus.imem_ready) begin nir++; ir_cyc = cyc; ird = bus.imem_rdata; ierr = bus.imem_error; order.push_back(1'b0); end
    if (bus.dmem_ready) begin ndr++; dr_cyc = cyc; drd = bus.dmem_rdata; derr = bus.dmem_error; order.push_back(1'b1); end
    if (!reset) begin
      act = 0; lastd = 0; prst = 1;
    end else begin
      prst = 0;
      if (!act) begin
        if (bus.imem_valid || bus.dmem_valid) begin
          pd = bus.dmem_valid && (!bus.imem_valid || !lastd);
          lastd = pd; twho = pd; act = 1; st = cyc;
          ta = pd ? bus.dmem_addr : bus.imem_addr;
          twd = pd ? bus.dmem_wdata : 32'h0;
          tws = pd ? bus.dmem_wstrb : 4'h0;
          ts = region(ta);
          if (ts < 0) begin rc = cyc + 1; rd = 0; re = 1; end else rc = -1;
        end
      end else if (rc < 0) begin
        if (rdy[ts]) begin rc = cyc + 1; rd = srd[ts]; re = 0; end
        else if (cyc - st == TO) begin rc = cyc + 1; rd = 0; re = 1; end
      end else if (cyc == rc) act = 0;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask
  task automatic clear();
    for (int s = 0; s < 4; s++) begin nvalid[s] = 0; last_sv[s] = 0; end
    nir = 0; ndr = 0; ir_cyc = 0; dr_cyc = 0; order.delete();
  endtask
  task automatic run(input bit di, input logic [31:0] ia, input bit dd, input logic [31:0] da,
                     input logic [31:0] wd, input logic [3:0] ws);
    bit ig, dg;
    ig = !di; dg = !dd;
    bus.imem_valid = di; bus.imem_addr = ia;
    bus.dmem_valid = dd; bus.dmem_addr = da; bus.dmem_wdata = wd; bus.dmem_wstrb = ws;
    for (int i = 0; i < 40 && !(ig && dg); i++) begin
      @(negedge clock);
      if (bus.imem_ready) ig = 1;
      if (bus.dmem_ready) dg = 1;
      @(posedge clock);
      #1;
      if (ig) bus.imem_valid = 0;
      if (dg) bus.dmem_valid = 0;
    end
    chk("run_completed", 32'({ig, dg}), 32'h3);
    bus.imem_valid = 0; bus.dmem_valid = 0;
  endtask

  logic [31:0] taddr[11] = '{32'h00003FFC, 32'h00004000, 32'h000FFFFC, 32'h00100000, 32'h00100004,
                             32'h0200BFFC, 32'h0200C000, 32'h0BFFFFFC, 32'h0C000000, 32'h0FFFFFFC,
                             32'h10000000};
  bit          terr[11]  = '{0, 1, 1, 0, 1, 0, 1, 1, 0, 0, 1};
  int          s0;

  initial begin
    bus.imem_valid = 0; bus.imem_addr = 0;
    bus.dmem_valid = 0; bus.dmem_addr = 0; bus.dmem_wdata = 0; bus.dmem_wstrb = 0;
    clear();
    tick(3);
    reset = 1;
    tick(1);
    // uart write, ready on the third valid cycle
    clear();
    run(0, 0, 1, 32'h00100000, 32'hA5A5A5A5, 4'hF);
    chk("t1_uart_cycles", 32'(nvalid[1]), 32'd3);
    chk("t1_dresp_count", 32'(ndr), 32'd1);
    chk("t1_resp_delay", 32'(dr_cyc - last_sv[1]), 32'd1);
    chk("t1_error", 32'(derr), 32'd0);
    // simultaneous requests right after reset: dmem first
    reset = 0; tick(2); reset = 1;
    clear();
    run(1, 32'h00000040, 1, 32'h00000080, 32'h0, 4'h0);
    chk("t2_count", 32'(order.size()), 32'd2);
    if (order.size() == 2) begin
      chk("t2_first_dmem", 32'(order[0]), 32'd1);
      chk("t2_second_imem", 32'(order[1]), 32'd0);
    end
    chk("t2_pulses", 32'({nir[7:0], ndr[7:0]}), 32'h0101);
    // fetch from bram
    clear(); s0 = cyc + 1;
    run(1, 32'h00000010, 0, 0, 0, 0);
    chk("t3_rdata", ird, 32'hDEADBEEF);
    chk("t3_latency", 32'(ir_cyc - s0), 32'd2);
    // unmapped data read
    clear(); s0 = cyc + 1;
    run(0, 0, 1, 32'h20000000, 0, 0);
    chk("t4_no_select", 32'(nvalid[0] + nvalid[1] + nvalid[2] + nvalid[3]), 32'd0);
    chk("t4_latency", 32'(dr_cyc - s0), 32'd1);
    chk("t4_err_rdata", {drd[30:0], derr}, 32'h1);
    // plic never answers
    clear();
    run(0, 0, 1, 32'h0C000004, 0, 0);
    chk("t5_plic_cycles", 32'(nvalid[3]), 32'd8);
    chk("t5_error", 32'(derr), 32'd1);
    chk("t5_resp_delay", 32'(dr_cyc - last_sv[3]), 32'd1);
    // reset during clint access
    lat[2] = 0; clear();
    bus.dmem_valid = 1; bus.dmem_addr = 32'h02000008; bus.dmem_wdata = 32'h0; bus.dmem_wstrb = 4'h0;
    tick(3);
    chk("t6_clint_active", 32'(bus.clint_valid), 32'd1);
    reset = 0; bus.dmem_valid = 0;
    tick(2);
    chk("t6_clint_cleared", 32'(bus.clint_valid), 32'd0);
    chk("t6_no_resp", 32'(ndr), 32'd0);
    chk("t6_addr_cleared", bus.mem_addr, 32'h0);
    reset = 1; lat[2] = 1; clear();
    run(0, 0, 1, 32'h02000008, 0, 0);
    chk("t6_after_reset", {drd, derr} == {32'h12345678, 1'b0} ? 32'd1 : 32'd0, 32'd1);
    // region boundaries
    lat[3] = 2;
    for (int i = 0; i < 11; i++) begin
      clear();
      run(0, 0, 1, taddr[i], 0, 0);
      chk($sformatf("t7_err_%h", taddr[i]), 32'(derr), 32'(terr[i]));
    end
    // stray ready from an unselected slave, alternation after a dmem grant
    noise = 4'b0010; lat[0] = 2; clear();
    run(1, 32'h00000100, 1, 32'h00000200, 32'h11223344, 4'h3);
    chk("t8_count", 32'(order.size()), 32'd2);
    if (order.size() == 2) chk("t8_first_imem", 32'(order[0]), 32'd0);
    chk("t8_bram_cycles", 32'(nvalid[0]), 32'd4);
    noise = 4'b0;
    tick(2);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
